// File: rtl/relay_pkg.sv
// Shared types and helpers for the relay receive path.
// Optional parity support elsewhere is selected with RELAY_RX_PARITY_EN.
package relay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } relay_state_e;

    localparam int DEFAULT_SAMPLES_PER_BIT = 32;

    // Width that holds every value 0..spb, so the ones counter never wraps.
    function automatic int slicer_cnt_width(input int spb);
        return $clog2(spb + 1);
    endfunction

endpackage

// File: rtl/relay_bit_slicer.sv
// Majority-vote bit slicer: votes over SAMPLES_PER_BIT consecutive samples and
// pulses bit_valid the cycle after the last sample; clear restarts the window.
module relay_bit_slicer
    import relay_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic sample_in,
    output logic bit_out,
    output logic bit_valid
);

    localparam int CW = slicer_cnt_width(SAMPLES_PER_BIT);
    localparam logic [CW-1:0] LAST_SAMPLE = CW'(SAMPLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF        = CW'(SAMPLES_PER_BIT / 2);

    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] ones_next;

    assign ones_next = ones_cnt + CW'(sample_in);

    // The window restarts on the edge that closes the previous one, so the
    // sample presented during the bit_valid cycle is sample 0 of the next bit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (sample_cnt == LAST_SAMPLE) begin
                bit_out    <= (ones_next > HALF);
                bit_valid  <= 1'b1;
                sample_cnt <= '0;
                ones_cnt   <= '0;
            end else begin
                sample_cnt <= sample_cnt + CW'(1);
                ones_cnt   <= ones_next;
            end
        end
    end

endmodule

// File: rtl/relay_rx_sequencer.sv
// Frame sequencer for the relay receive path: start, LSB-first data, optional
// even parity (RELAY_RX_PARITY_EN), stop; completed bytes go to a holding register.
module relay_rx_sequencer
    import relay_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] frame_data,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int IDXW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_BITS - 1);

    relay_state_e          state;
    relay_state_e          next_state;
    relay_state_e          restart_state;
    logic [IDXW-1:0]       bit_idx;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  slicer_clear;
    logic                  bit_out;
    logic                  bit_valid;
    logic                  stop_done;
    logic                  good_q;
    logic                  parity_bad;

    relay_bit_slicer #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_slicer (
        .clk       (clk),
        .reset     (reset),
        .clear     (slicer_clear),
        .sample_in (data_in),
        .bit_out   (bit_out),
        .bit_valid (bit_valid)
    );

    // Leaving a frame on a 1 sample treats that sample as the next start bit.
    assign restart_state = data_in ? START : IDLE;
    assign stop_done     = enable && (state == STOP) && bit_valid;
    assign busy          = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (data_in) next_state = START;
            START:  if (bit_valid) next_state = bit_out ? DATA : restart_state;
            DATA: begin
                if (bit_valid && (bit_idx == LAST_IDX)) begin
`ifdef RELAY_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
            PARITY: if (bit_valid) next_state = STOP;
            STOP:   if (bit_valid) next_state = restart_state;
            default: next_state = IDLE;
        endcase
        if (!enable) next_state = IDLE;
    end

    assign slicer_clear = (next_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state <= next_state;
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_valid) begin
                shift_reg[bit_idx] <= bit_out;
                bit_idx            <= bit_idx + IDXW'(1);
            end
        end
    end

`ifdef RELAY_RX_PARITY_EN
    // Even parity: the parity bit must equal the XOR of the data bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == START) parity_bad <= 1'b0;
            else if (state == PARITY && bit_valid) parity_bad <= (bit_out != ^shift_reg);
            parity_err <= stop_done && parity_bad;
        end
    end
`else
    assign parity_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Holding register: a byte transfers on any edge where frame_valid and
    // frame_ready are both high; frame_data is frozen while valid waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            good_q      <= 1'b0;
            frame_err   <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            good_q    <= stop_done && !bit_out && !parity_bad;
            frame_err <= stop_done && bit_out;
            if (good_q && (!frame_valid || frame_ready)) begin
                frame_data  <= shift_reg;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (good_q && frame_valid && !frame_ready) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_relay_rx_sequencer.sv
// Directed bench for relay_rx_sequencer: clean frames, glitch, stop error,
// overrun, majority tie and mid-frame reset, with hand-computed expectations.
module tb_relay_rx_sequencer;

    localparam int SPB = 32;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          data_in;
    logic [DB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic          overrun;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    relay_rx_sequencer #(
        .SAMPLES_PER_BIT(SPB),
        .DATA_BITS      (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .data_in     (data_in),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sample per clock; inputs change 1 time unit after the edge.
    task automatic step(input logic d);
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < SPB; i++) step(i < n);
    endtask

    // bit0_ones >= 0 overrides data bit 0 with that many leading ones.
    task automatic send_frame(input logic [DB-1:0] b, input logic stop_v, input int bit0_ones);
        send_ones(SPB);
        for (int i = 0; i < DB; i++) begin
            if (i == 0 && bit0_ones >= 0) send_ones(bit0_ones);
            else send_ones(b[i] ? SPB : 0);
        end
`ifdef RELAY_RX_PARITY_EN
        send_ones((^b) ? SPB : 0);
`endif
        send_ones(stop_v ? SPB : 0);
        data_in = 1'b0;
    endtask

    initial begin
        logic seen;
        reset       = 1'b1;
        enable      = 1'b0;
        data_in     = 1'b0;
        frame_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_data", frame_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        reset  = 1'b0;
        enable = 1'b1;
        step(0);

        // Clean 0xA5: valid appears 321 edges after start sample 0.
        send_frame(8'hA5, 1'b0, -1);
        step(0);
        check("a5_valid_early", frame_valid, 0);
        check("a5_busy_done", busy, 0);
        step(0);
        check("a5_valid", frame_valid, 1);
        check("a5_data", frame_data, 8'hA5);
        check("a5_frame_err", frame_err, 0);
        check("a5_parity_err", parity_err, 0);
        step(0);
        check("a5_valid_pulse", frame_valid, 0);

        // Glitch: 10 ones then zeros votes 0 on the start bit.
        for (int i = 0; i < 10; i++) step(1);
        for (int i = 0; i < 22; i++) step(0);
        check("glitch_busy_in", busy, 1);
        step(0);
        check("glitch_idle", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | frame_err | frame_valid;
            step(0);
        end
        check("glitch_no_out", seen, 0);

        // Bad stop bit with 0x3C.
        send_frame(8'h3C, 1'b1, -1);
        step(0);
        check("stop_frame_err", frame_err, 1);
        check("stop_valid", frame_valid, 0);
        step(0);
        check("stop_err_pulse", frame_err, 0);
        check("stop_valid2", frame_valid, 0);

        // Overrun: consumer stalled across two frames.
        frame_ready = 1'b0;
        send_frame(8'h11, 1'b0, -1);
        step(0);
        step(0);
        check("ovr_first_valid", frame_valid, 1);
        check("ovr_first_data", frame_data, 8'h11);
        check("ovr_none_yet", overrun, 0);
        send_frame(8'h22, 1'b0, -1);
        step(0);
        step(0);
        check("ovr_set", overrun, 1);
        check("ovr_data_kept", frame_data, 8'h11);
        check("ovr_valid_kept", frame_valid, 1);
        frame_ready = 1'b1;
        step(0);
        check("ovr_valid_clear", frame_valid, 0);
        check("ovr_sticky", overrun, 1);

        // Majority tie on bit 0 slices to 0.
        send_frame(8'hFF, 1'b0, SPB / 2);
        step(0);
        step(0);
        check("tie_valid", frame_valid, 1);
        check("tie_data", frame_data, 8'hFE);
        step(0);

        // Reset at sample 100 of a 0x5A frame, then a clean 0x5A.
        send_ones(SPB);
        send_ones(0);
        send_ones(SPB);
        for (int i = 0; i < 4; i++) step(0);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        step(1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", frame_valid, 0);
        check("mid_rst_data", frame_data, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_frame_err", frame_err, 0);
        reset = 1'b0;
        step(0);
        send_frame(8'h5A, 1'b0, -1);
        step(0);
        step(0);
        check("post_rst_valid", frame_valid, 1);
        check("post_rst_data", frame_data, 8'h5A);
        check("post_rst_frame_err", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
